// File: rtl/sd_cmd_pkg.sv
// Shared SD command-line definitions: FSM state encoding, frame geometry and the
// CRC7 generator polynomial with its single-bit update step.
package sd_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_TURN      = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RECV      = 3'd5,
        ST_DELIVER   = 3'd6,
        ST_REL_WAIT  = 3'd7
    } cmd_state_e;

    localparam int FRAME_W = 48;
    localparam int TOKEN_W = 40;
    localparam int CRC_W   = 7;

    // x^7 + x^3 + 1 with the implicit x^7 term dropped
    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc,
                                                   input logic din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator; clear seeds the register to zero and, if enable is
// also high, folds the current bit into that zero seed in the same cycle.
module crc7_serial
    import sd_cmd_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_r;

    // CRC register update
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            crc_r <= 7'h00;
        end else if (clear) begin
            crc_r <= enable ? crc7_step(7'h00, bit_in) : 7'h00;
        end else if (enable) begin
            crc_r <= crc7_step(crc_r, bit_in);
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/cmd_phys.sv
// SD CMD-line physical layer: serialises a 40-bit command token with CRC7 and end
// bit, then captures the 48-bit response. Optional response CRC/end-bit check and
// crc_err port are enabled with `define CMD_PHYS_RESP_CRC_CHECK_EN.
module cmd_phys
    import sd_cmd_pkg::*;
#(
    parameter int RESP_TIMEOUT = 64,
    parameter int TURNAROUND   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_in,
    input  logic [TOKEN_W-1:0] cmd_in,
    output logic               ack_out,
    output logic               req_out,
    output logic [TOKEN_W-1:0] cmd_out,
    input  logic               ack_in,
    output logic               cmd_pin_out,
    output logic               cmd_pin_oe,
    input  logic               cmd_pin_in,
    output logic               idle_out,
    output logic               timeout_err
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
    ,
    output logic               crc_err
`endif
);

    localparam int TMO_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(RESP_TIMEOUT - 1);
    localparam logic [5:0]       TURN_LAST = 6'(TURNAROUND - 1);

    cmd_state_e         state_r, state_next_s;
    logic [FRAME_W-1:0] shift_r;
    logic [5:0]         bit_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic               ack_r, req_r, pin_r, oe_r, idle_r, timeout_r;
    logic [TOKEN_W-1:0] cmd_out_r;
    logic               crc_clr_s, crc_en_s, crc_bit_s;
    logic [CRC_W-1:0]   crc_s;
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
    logic               crc_err_r;
`endif

    crc7_serial u_crc (
        .clock  (clock),
        .reset  (reset),
        .clear  (crc_clr_s),
        .enable (crc_en_s),
        .bit_in (crc_bit_s),
        .crc    (crc_s)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and CRC control. The pin register runs one bit ahead of the
    // CRC, so token bits 1..39 are folded in during SEND counts 0..38.
    always_comb begin
        state_next_s = state_r;
        crc_clr_s    = 1'b0;
        crc_en_s     = 1'b0;
        crc_bit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_in) state_next_s = ST_LOAD;
                else        state_next_s = ST_IDLE;
            end
            ST_LOAD: begin
                state_next_s = ST_SEND;
                crc_clr_s    = 1'b1;
                crc_en_s     = 1'b1;
                crc_bit_s    = shift_r[FRAME_W-1];
            end
            ST_SEND: begin
                crc_en_s  = (bit_cnt_r < 6'd39);
                crc_bit_s = shift_r[FRAME_W-1];
                if (bit_cnt_r == 6'd47) state_next_s = ST_TURN;
                else                    state_next_s = ST_SEND;
            end
            ST_TURN: begin
                if (bit_cnt_r == TURN_LAST) state_next_s = ST_WAIT_RESP;
                else                        state_next_s = ST_TURN;
            end
            ST_WAIT_RESP: begin
                if (!cmd_pin_in) begin
                    state_next_s = ST_RECV;
                    crc_clr_s    = 1'b1;
                    crc_en_s     = 1'b1;
                    crc_bit_s    = cmd_pin_in;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    state_next_s = ST_DELIVER;
                end else begin
                    state_next_s = ST_WAIT_RESP;
                end
            end
            ST_RECV: begin
                crc_en_s  = (bit_cnt_r < 6'd40);
                crc_bit_s = cmd_pin_in;
                if (bit_cnt_r == 6'd47) state_next_s = ST_DELIVER;
                else                    state_next_s = ST_RECV;
            end
            ST_DELIVER: begin
                if (ack_in) state_next_s = ST_REL_WAIT;
                else        state_next_s = ST_DELIVER;
            end
            ST_REL_WAIT: begin
                if (!ack_in) state_next_s = ST_IDLE;
                else         state_next_s = ST_REL_WAIT;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_r   <= 48'h0;
            bit_cnt_r <= 6'd0;
            tmo_cnt_r <= '0;
            ack_r     <= 1'b0;
            req_r     <= 1'b0;
            pin_r     <= 1'b1;
            oe_r      <= 1'b0;
            idle_r    <= 1'b1;
            timeout_r <= 1'b0;
            cmd_out_r <= 40'h0;
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
            crc_err_r <= 1'b0;
`endif
        end else begin
            idle_r    <= (state_next_s == ST_IDLE);
            timeout_r <= 1'b0;
            // ack follows the request level, not the serial progress
            if (state_r == ST_IDLE && req_in) ack_r <= 1'b1;
            else if (!req_in)                 ack_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (req_in) begin
                        shift_r   <= {cmd_in, 8'h00};
                        bit_cnt_r <= 6'd0;
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
                        crc_err_r <= 1'b0;
`endif
                    end
                end
                ST_LOAD: begin
                    pin_r     <= shift_r[FRAME_W-1];
                    shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                    oe_r      <= 1'b1;
                    bit_cnt_r <= 6'd0;
                end
                ST_SEND: begin
                    if (bit_cnt_r == 6'd47) begin
                        oe_r      <= 1'b0;
                        pin_r     <= 1'b1;
                        bit_cnt_r <= 6'd0;
                    end else if (bit_cnt_r == 6'd39) begin
                        // CRC is complete here; queue its tail and the end bit
                        pin_r     <= crc_s[CRC_W-1];
                        shift_r   <= {crc_s[CRC_W-2:0], 1'b1, 41'd0};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end else begin
                        pin_r     <= shift_r[FRAME_W-1];
                        shift_r   <= {shift_r[FRAME_W-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_TURN: begin
                    if (bit_cnt_r == TURN_LAST) begin
                        bit_cnt_r <= 6'd0;
                        tmo_cnt_r <= '0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_WAIT_RESP: begin
                    if (!cmd_pin_in) begin
                        shift_r   <= {shift_r[FRAME_W-2:0], cmd_pin_in};
                        bit_cnt_r <= 6'd1;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        timeout_r <= 1'b1;
                        cmd_out_r <= 40'h0;
                        req_r     <= 1'b1;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RECV: begin
                    shift_r <= {shift_r[FRAME_W-2:0], cmd_pin_in};
                    if (bit_cnt_r == 6'd47) begin
                        cmd_out_r <= shift_r[FRAME_W-2:CRC_W];
                        req_r     <= 1'b1;
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
                        crc_err_r <= (shift_r[CRC_W-1:0] != crc_s) || (cmd_pin_in != 1'b1);
`endif
                    end else begin
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_DELIVER: begin
                    if (ack_in) req_r <= 1'b0;
                end
                ST_REL_WAIT: begin
                    bit_cnt_r <= 6'd0;
                end
                default: begin
                    oe_r  <= 1'b0;
                    pin_r <= 1'b1;
                end
            endcase
        end
    end

    assign ack_out     = ack_r;
    assign req_out     = req_r;
    assign cmd_out     = cmd_out_r;
    assign cmd_pin_out = pin_r;
    assign cmd_pin_oe  = oe_r;
    assign idle_out    = idle_r;
    assign timeout_err = timeout_r;
`ifdef CMD_PHYS_RESP_CRC_CHECK_EN
    assign crc_err     = crc_err_r;
`endif

endmodule
